// File: rtl/ram_pair_sum_master.sv
// ram_pair_sum_master
// Bus initiator for the 1024x10 paired-read scratch RAM. On start it reads an
// operand pointer from address 0, fetches the two operands at ptr and ptr+1,
// adds them as 10-bit two's complement and writes the sum to ptr+2.
// All address arithmetic wraps modulo 1024.
//
// Optional feature macro: RAM_PAIR_FETCH_EN
//   When defined, an even pointer lets both operands come from the single
//   aligned pair read in OPA, so the OPB state is skipped.
//
// Handshake: start is sampled only in IDLE; busy is high in every other state;
// done pulses for one cycle once the write-back edge has happened. result and
// overflow are valid from the done cycle until the next write-back.
// state_dbg exposes the FSM state encoding for checkers.
module ram_pair_sum_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [9:0]  result,
  output logic        overflow,
  output logic [9:0]  mem_addr,
  output logic        mem_we,
  output logic [19:0] mem_wdata,
  input  logic [19:0] mem_rdata,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PTR   = 3'd1,
    S_OPA   = 3'd2,
    S_OPB   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     state;
  logic [9:0] ptr;
  logic [9:0] op_a;
  logic [9:0] op_b;
  logic [9:0] sum;
  logic       sum_ovf;
  logic [9:0] ptr_p1;
  logic [9:0] ptr_p2;

  // Operand sum and signed-overflow flag (same-sign inputs, different-sign sum).
  always_comb begin
    sum     = op_a + op_b;
    sum_ovf = (op_a[9] == op_b[9]) && (sum[9] != op_a[9]);
    ptr_p1  = ptr + 10'd1;
    ptr_p2  = ptr + 10'd2;
  end

  // Bus drive is a pure decode of state and registered pointer/sum, so an
  // asynchronous reset drops mem_we without waiting for a clock edge.
  always_comb begin
    mem_addr  = 10'd0;
    mem_we    = 1'b0;
    mem_wdata = 20'd0;
    case (state)
      S_OPA:   mem_addr = ptr;
      S_OPB:   mem_addr = ptr_p1;
      S_WRITE: begin
        mem_addr  = ptr_p2;
        mem_we    = 1'b1;
        mem_wdata = {sum, 10'd0};
      end
      default: mem_addr = 10'd0;
    endcase
  end

  assign state_dbg = state;

  // Main FSM with registered busy/done/result/overflow and operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 10'd0;
      overflow <= 1'b0;
      ptr      <= 10'd0;
      op_a     <= 10'd0;
      op_b     <= 10'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_PTR;
            busy  <= 1'b1;
          end
        end
        S_PTR: begin
          ptr   <= mem_rdata[9:0];
          state <= S_OPA;
        end
        S_OPA: begin
          // Lane is picked by the low address bit of the read.
          op_a  <= ptr[0] ? mem_rdata[19:10] : mem_rdata[9:0];
          state <= S_OPB;
`ifdef RAM_PAIR_FETCH_EN
          if (!ptr[0]) begin
            // Aligned pointer: the pair read already holds both operands.
            op_b  <= mem_rdata[19:10];
            state <= S_WRITE;
          end
`endif
        end
        S_OPB: begin
          op_b  <= ptr_p1[0] ? mem_rdata[19:10] : mem_rdata[9:0];
          state <= S_WRITE;
        end
        S_WRITE: begin
          result   <= sum;
          overflow <= sum_ovf;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_pair_sum_master.sv
// Bench for ram_pair_sum_master: paired-read RAM model, scoreboard of expected
// write-backs, latency and bus-sequence checks, mid-operation reset and
// back-to-back start behaviour.
module tb_ram_pair_sum_master;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [9:0]  result;
  logic        overflow;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [19:0] mem_wdata;
  logic [19:0] mem_rdata;
  logic [2:0]  state_dbg;

  localparam logic [2:0] OPB_CODE = 3'd3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int opb_cnt = 0;
  bit collect = 0;

  // {write address, overflow, sum}
  logic [20:0] exp_q[$];
  int          done_cyc[$];

  logic [9:0] ram [0:1023];

  ram_pair_sum_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  assign mem_rdata = {ram[mem_addr | 10'd1], ram[mem_addr & ~10'd1]};

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata[19:10];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitors ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        check("result", {22'd0, result}, {22'd0, e[9:0]});
        check("overflow", {31'd0, overflow}, {31'd0, e[10]});
        check("ram_writeback", {22'd0, ram[e[20:11]]}, {22'd0, e[9:0]});
      end
      if (collect) done_cyc.push_back(cyc);
    end
    if (rst_n && state_dbg == OPB_CODE) opb_cnt++;
  end

  // ---------------- driver tasks ----------------
  // Reference model: computes the expected sum from the current RAM image.
  task automatic push_expected(output int exp_lat);
    logic [9:0] p, a, b, s;
    int         si;
    p  = ram[0];
    a  = ram[p];
    b  = ram[p + 10'd1];
    s  = a + b;
    si = $signed(a) + $signed(b);
    exp_q.push_back({p + 10'd2, (si > 511 || si < -512), s});
`ifdef RAM_PAIR_FETCH_EN
    exp_lat = p[0] ? 5 : 4;
`else
    exp_lat = 5;
`endif
  endtask

  task automatic run_op(output logic [39:0] seq);
    int exp_lat;
    int n;
    push_expected(exp_lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seq = '0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i <= 4) seq[(i-1)*10 +: 10] = mem_addr;
      if (i == 1) check("busy_active", {31'd0, busy}, 32'd1);
      if (done) begin
        n = i;
        break;
      end
    end
    check("done_latency", n, exp_lat);
    @(negedge clk);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic load_basic();
    ram[0]  = 10'd10;
    ram[10] = 10'd5;
    ram[11] = 10'd3;
    ram[12] = 10'h155;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [39:0] seq;
    int          opb_before;
    int          period;

    for (int i = 0; i < 1024; i++) ram[i] = 10'd0;
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_result",   {22'd0, result},   32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_addr",     {22'd0, mem_addr}, 32'd0);
    check("rst_we",       {31'd0, mem_we},   32'd0);
    check("rst_wdata",    {12'd0, mem_wdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic add
    load_basic();
    run_op(seq);

    // Negative add
    ram[10] = 10'h3FB;
    ram[11] = 10'h3FD;
    run_op(seq);
    check("neg_ram12", {22'd0, ram[12]}, 32'h3F8);

    // Signed overflow; OPB only visited without the pair-fetch feature
    ram[0]  = 10'd20;
    ram[20] = 10'h1FF;
    ram[21] = 10'd1;
    opb_before = opb_cnt;
    run_op(seq);
`ifdef RAM_PAIR_FETCH_EN
    check("ovf_opb_visits", opb_cnt - opb_before, 0);
`else
    check("ovf_opb_visits", opb_cnt - opb_before, 1);
`endif

    // Wrap with odd pointer
    ram[0]    = 10'd1023;
    ram[1023] = 10'd7;
    ram[1]    = 10'h2AA;
    run_op(seq);
    check("wrap_addr_seq", {22'd0, seq[9:0]},   32'd0);
    check("wrap_addr_seq", {22'd0, seq[19:10]}, 32'd1023);
    check("wrap_addr_seq", {22'd0, seq[29:20]}, 32'd0);
    check("wrap_addr_seq", {22'd0, seq[39:30]}, 32'd1);
    check("wrap_ram1", {22'd0, ram[1]}, 32'd6);

    // Random operands at random pointers (kept clear of address 0..2)
    for (int t = 0; t < 6; t++) begin
      logic [9:0] p;
      p = 10'($urandom_range(3, 1020));
      ram[0]       = p;
      ram[p]       = 10'($urandom_range(0, 1023));
      ram[p+10'd1] = 10'($urandom_range(0, 1023));
      run_op(seq);
    end

    // Reset mid-operation (cycle k+3: OPB, or WRITE with pair fetch)
    load_basic();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  {31'd0, busy},     32'd0);
    check("midrst_we",    {31'd0, mem_we},   32'd0);
    check("midrst_addr",  {22'd0, mem_addr}, 32'd0);
    check("midrst_wdata", {12'd0, mem_wdata}, 32'd0);
    check("midrst_result", {22'd0, result},  32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_ram12_kept", {22'd0, ram[12]}, 32'h155);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(seq);

    // Back-to-back starts with start held for 20 edges
    load_basic();
`ifdef RAM_PAIR_FETCH_EN
    period = 5;
`else
    period = 6;
`endif
    for (int j = 0; j < 4; j++) exp_q.push_back({10'd12, 1'b0, 10'd8});
    collect = 1'b1;
    @(negedge clk);
    start = 1'b1;
    repeat (20) @(posedge clk);
    #1 start = 1'b0;
    for (int w = 0; w < 40 && exp_q.size() != 0; w++) @(negedge clk);
    repeat (8) @(negedge clk);
    collect = 1'b0;
    check("b2b_queue_drained", exp_q.size(), 0);
    check("b2b_done_count", done_cyc.size(), 4);
    for (int j = 1; j < done_cyc.size(); j++)
      check("b2b_done_period", done_cyc[j] - done_cyc[j-1], period);
    check("b2b_idle_after", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
